roba_mult_pipe: RTL and testbench

- Parametrised, pipelined successor to the team's combinational 16-bit rounding-based approximate (ROBA) multiplier.
- Computes P = Ar*B + Br*A - Ar*Br, where Ar and Br are |A| and |B| rounded to the nearest power of two.
- Adds per-transaction exact/approximate mode, signed/unsigned operation, tag passthrough, and a valid/ready handshake with backpressure.
- Sits between operand producers and an accumulator/datapath stage in the approximate-arithmetic evaluation fabric.

---
 rtl/roba_mult_pipe.sv | 127 ++++++++++++
 tb/tb_roba_mult_pipe.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/roba_mult_pipe.sv
// Three-stage pipelined ROBA approximate / exact multiplier with valid/ready flow control.
// P = Ar*B + Br*A - Ar*Br, where Ar and Br are the operand magnitudes rounded to a power of two.
module roba_mult_pipe #(
   parameter int WIDTH  = 16,
   parameter bit SIGNED = 1'b1,
   parameter int TAG_W  = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_valid,
   output logic               i_ready,
   input  logic [WIDTH-1:0]   i_a,
   input  logic [WIDTH-1:0]   i_b,
   input  logic               i_mode,
   input  logic [TAG_W-1:0]   i_tag,
   output logic               o_valid,
   input  logic               o_ready,
   output logic [2*WIDTH-1:0] o_p,
   output logic [TAG_W-1:0]   o_tag
);

   localparam int KW = $clog2(WIDTH) + 1;
   localparam int PW = 2 * WIDTH;
   localparam int SW = PW + 2;

   typedef struct packed {
      logic             mode;
      logic             sign;
      logic             zero;
      logic [TAG_W-1:0] tag;
      logic [WIDTH-1:0] abs_a;
      logic [WIDTH-1:0] abs_b;
      logic [KW-1:0]    ka;
      logic [KW-1:0]    kb;
   } s1_t;

   logic            en;
   logic            s1_valid_q, s2_valid_q, o_valid_q;
   s1_t             s1_d, s1_q;
   logic [SW-1:0]   s2_s_d, s2_s_q;
   logic [SW-1:0]   s2_t3_d, s2_t3_q;
   logic            s2_sign_q, s2_zero_q;
   logic [TAG_W-1:0] s2_tag_q;
   logic [PW-1:0]   m_mag, o_p_d, o_p_q;
   logic [TAG_W-1:0] o_tag_q;

   // Position of the leading one, bumped by one when the next bit down is set (m >= 2 only).
   function automatic logic [KW-1:0] round_exp(input logic [WIDTH-1:0] x);
      logic [WIDTH:0] xs;
      logic [KW-1:0]  k;
      xs = {x, 1'b0};
      k  = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (x[i]) k = (i >= 2 && xs[i]) ? KW'(i + 1) : KW'(i);
      end
      return k;
   endfunction

   assign en      = ~o_valid_q | o_ready;
   assign i_ready = en;
   assign o_valid = o_valid_q;
   assign o_p     = o_p_q;
   assign o_tag   = o_tag_q;

   always_comb begin : stage1
      logic sa, sb;
      // NOTE: every output of an always_comb gets a default first, so no path can infer a latch.
      s1_d       = '0;
      sa         = SIGNED && i_a[WIDTH-1];
      sb         = SIGNED && i_b[WIDTH-1];
      s1_d.abs_a = sa ? -i_a : i_a;
      s1_d.abs_b = sb ? -i_b : i_b;
      s1_d.ka    = round_exp(s1_d.abs_a);
      s1_d.kb    = round_exp(s1_d.abs_b);
      s1_d.zero  = (s1_d.abs_a == '0) || (s1_d.abs_b == '0);
      s1_d.sign  = sa ^ sb;
      s1_d.mode  = i_mode;
      s1_d.tag   = i_tag;
   end

   always_comb begin : stage2
      s2_s_d  = '0;
      s2_t3_d = '0;
      if (s1_q.mode) begin
         s2_s_d = SW'(s1_q.abs_a) * SW'(s1_q.abs_b);
      end else begin
         s2_s_d  = (SW'(s1_q.abs_b) << s1_q.ka) + (SW'(s1_q.abs_a) << s1_q.kb);
         s2_t3_d = SW'(1) << ({1'b0, s1_q.ka} + {1'b0, s1_q.kb});
      end
   end

   // The difference always fits PW bits; the zero flag wins over the formula.
   assign m_mag = s2_zero_q ? '0 : PW'(s2_s_q - s2_t3_q);
   assign o_p_d = s2_sign_q ? -m_mag : m_mag;

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
         o_valid_q  <= 1'b0;
         o_p_q      <= '0;
         o_tag_q    <= '0;
      end else if (en) begin
         s1_valid_q <= i_valid;
         s2_valid_q <= s1_valid_q;
         o_valid_q  <= s2_valid_q;
         if (s2_valid_q) begin
            o_p_q   <= o_p_d;
            o_tag_q <= s2_tag_q;
         end
      end
   end

   // NOTE: stage data registers carry no reset; the valid bits alone decide whether they mean anything.
   always_ff @(posedge clk) begin
      if (en) begin
         s1_q      <= s1_d;
         s2_s_q    <= s2_s_d;
         s2_t3_q   <= s2_t3_d;
         s2_sign_q <= s1_q.sign;
         s2_zero_q <= s1_q.zero;
         s2_tag_q  <= s1_q.tag;
      end
   end

endmodule

// File: tb/tb_roba_mult_pipe.sv
// Self-checking bench for roba_mult_pipe: signed W=16 instance with scoreboard, plus an unsigned instance.
module tb_roba_mult_pipe;

   localparam int W  = 16;
   localparam int PW = 32;
   localparam int TW = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic          i_valid, i_ready, i_mode, o_valid, o_ready;
   logic [W-1:0]  i_a, i_b;
   logic [TW-1:0] i_tag, o_tag;
   logic [PW-1:0] o_p;

   logic          u_valid, u_ready, u_mode, u_o_valid, u_o_ready;
   logic [W-1:0]  u_a, u_b;
   logic [TW-1:0] u_tag, u_o_tag;
   logic [PW-1:0] u_o_p;

   roba_mult_pipe #(.WIDTH(W), .SIGNED(1'b1), .TAG_W(TW)) dut (
      .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(i_ready), .i_a(i_a), .i_b(i_b),
      .i_mode(i_mode), .i_tag(i_tag), .o_valid(o_valid), .o_ready(o_ready), .o_p(o_p), .o_tag(o_tag)
   );

   roba_mult_pipe #(.WIDTH(W), .SIGNED(1'b0), .TAG_W(TW)) dut_u (
      .clk(clk), .rst(rst), .i_valid(u_valid), .i_ready(u_ready), .i_a(u_a), .i_b(u_b),
      .i_mode(u_mode), .i_tag(u_tag), .o_valid(u_o_valid), .o_ready(u_o_ready), .o_p(u_o_p),
      .o_tag(u_o_tag)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [PW-1:0] p;
      logic [TW-1:0] tag;
   } exp_t;
   exp_t sb[$];

   typedef struct {
      logic [W-1:0]  a;
      logic [W-1:0]  b;
      logic          mode;
      logic [PW-1:0] p;
   } vec_t;

   function automatic longint pow_round(input longint x);
      longint p = 1;
      while (p * 2 <= x) p = p * 2;
      if (p >= 4 && (x - p) * 2 >= p) p = p * 2;
      return p;
   endfunction

   function automatic logic [PW-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic mode);
      longint ma, mb, ar, br, m;
      bit     neg;
      ma  = a[W-1] ? (longint'(1) << W) - longint'(a) : longint'(a);
      mb  = b[W-1] ? (longint'(1) << W) - longint'(b) : longint'(b);
      neg = a[W-1] ^ b[W-1];
      if (ma == 0 || mb == 0) m = 0;
      else if (mode) m = ma * mb;
      else begin
         ar = pow_round(ma);
         br = pow_round(mb);
         m  = ar * mb + br * ma - ar * br;
      end
      if (neg) m = -m;
      return m[PW-1:0];
   endfunction

   logic          stalled_prev = 1'b0;
   logic [PW-1:0] held_p;
   logic [TW-1:0] held_tag;

   // One cycle of the signed port: called at a falling edge, returns at the next falling edge.
   task automatic step(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic mode, input logic [TW-1:0] tag, input logic ordy,
                       input logic [PW-1:0] exp_p, output logic acc);
      exp_t e;
      logic rdy_exp;
      i_valid = v; i_a = a; i_b = b; i_mode = mode; i_tag = tag; o_ready = ordy;
      #1;
      rdy_exp = !(o_valid && !o_ready);
      check("i_ready", i_ready, rdy_exp);
      if (stalled_prev && o_valid) begin
         check("hold_p", o_p, held_p);
         check("hold_tag", o_tag, held_tag);
      end
      if (o_valid && o_ready) begin
         if (sb.size() == 0) check("spurious_o_valid", o_valid, 1'b0);
         else begin
            e = sb.pop_front();
            check("o_p", o_p, e.p);
            check("o_tag", o_tag, e.tag);
         end
      end
      stalled_prev = o_valid && !o_ready;
      held_p       = o_p;
      held_tag     = o_tag;
      acc          = v && i_ready;
      if (acc) sb.push_back('{p: exp_p, tag: tag});
      @(negedge clk);
   endtask

   task automatic drain();
      logic acc;
      for (int k = 0; k < 20 && sb.size() != 0; k++) step(1'b0, '0, '0, 1'b0, '0, 1'b1, '0, acc);
      check("drain_left", sb.size(), 0);
      for (int k = 0; k < 3; k++) step(1'b0, '0, '0, 1'b0, '0, 1'b1, '0, acc);
   endtask

   task automatic u_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic mode, input logic [PW-1:0] exp_p);
      u_a = a; u_b = b; u_mode = mode; u_tag = 4'hA; u_valid = 1'b1;
      #1;
      check({name, "_ready"}, u_ready, 1'b1);
      @(negedge clk);
      u_valid = 1'b0;
      for (int k = 0; k < 6 && !u_o_valid; k++) @(negedge clk);
      check({name, "_valid"}, u_o_valid, 1'b1);
      check(name, u_o_p, exp_p);
      check({name, "_tag"}, u_o_tag, 4'hA);
      @(negedge clk);
   endtask

   // Internal difference before truncation must keep its top two bits clear.
   logic [PW+1:0] diff_s, diff_u;
   always @(negedge clk) begin
      if (!rst) begin
         diff_s = dut.s2_s_q - dut.s2_t3_q;
         diff_u = dut_u.s2_s_q - dut_u.s2_t3_q;
         if (dut.s2_valid_q && !dut.s2_zero_q) check("upper_bits_s", diff_s[PW+1:PW], 2'b00);
         if (dut_u.s2_valid_q && !dut_u.s2_zero_q) check("upper_bits_u", diff_u[PW+1:PW], 2'b00);
      end
   end

   initial begin
      vec_t          vecs[13];
      logic          acc;
      logic [W-1:0]  ra, rb;
      logic          rm;
      int            bi, cyc;
      logic [TW-1:0] tag_ctr;

      vecs[0]  = '{16'd100,  16'd100,  1'b0, 32'd9216};
      vecs[1]  = '{16'd100,  16'd100,  1'b1, 32'd10000};
      vecs[2]  = '{16'hFFFB, 16'd7,    1'b0, 32'hFFFF_FFDC};
      vecs[3]  = '{16'hFFFB, 16'd7,    1'b1, 32'hFFFF_FFDD};
      vecs[4]  = '{16'd3,    16'd3,    1'b0, 32'd8};
      vecs[5]  = '{16'h8000, 16'h8000, 1'b0, 32'h4000_0000};
      vecs[6]  = '{16'h8000, 16'h8000, 1'b1, 32'h4000_0000};
      vecs[7]  = '{16'd0,    16'd1234, 1'b0, 32'd0};
      vecs[8]  = '{16'd0,    16'd1234, 1'b1, 32'd0};
      vecs[9]  = '{16'd1,    16'hFFFF, 1'b0, 32'hFFFF_FFFF};
      vecs[10] = '{16'd6,    16'd5,    1'b0, 32'd32};
      vecs[11] = '{16'h7FFF, 16'h7FFF, 1'b0, 32'h3FFF_0000};
      vecs[12] = '{16'd5,    16'd0,    1'b0, 32'd0};

      i_valid = 1'b0; i_a = '0; i_b = '0; i_mode = 1'b0; i_tag = '0; o_ready = 1'b1;
      u_valid = 1'b0; u_a = '0; u_b = '0; u_mode = 1'b0; u_tag = '0; u_o_ready = 1'b1;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_o_valid", o_valid, 1'b0);
      check("rst_o_p", o_p, '0);
      check("rst_o_tag", o_tag, '0);
      check("rst_u_o_valid", u_o_valid, 1'b0);
      rst = 1'b0;

      // Directed table, back-to-back
      foreach (vecs[i]) step(1'b1, vecs[i].a, vecs[i].b, vecs[i].mode, TW'(i), 1'b1, vecs[i].p, acc);
      drain();

      // Backpressure: eight beats, consumer stalls on cycles 4..6
      bi = 0;
      cyc = 1;
      while (bi < 8 && cyc < 40) begin
         ra = W'(37 * bi + 3);
         rb = W'(16'hFF00 + 16'(bi * 11));
         step(1'b1, ra, rb, bi[0], TW'(bi), !(cyc >= 4 && cyc <= 6), model(ra, rb, bi[0]), acc);
         if (acc) bi++;
         cyc++;
      end
      check("bp_all_accepted", bi, 8);
      drain();

      // Random traffic with random backpressure
      tag_ctr = '0;
      for (int k = 0; k < 60; k++) begin
         ra = W'($urandom);
         rb = W'($urandom);
         rm = 1'($urandom_range(0, 1));
         step(($urandom_range(0, 3) != 0), ra, rb, rm, tag_ctr, ($urandom_range(0, 2) != 0),
              model(ra, rb, rm), acc);
         if (acc) tag_ctr++;
      end
      drain();

      // Reset with three beats in flight
      for (int k = 0; k < 3; k++) step(1'b1, W'(k + 9), 16'd77, 1'b0, TW'(k), 1'b0,
                                       model(W'(k + 9), 16'd77, 1'b0), acc);
      i_valid = 1'b0; o_ready = 1'b0; rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("mid_rst_o_valid", o_valid, 1'b0);
      check("mid_rst_o_p", o_p, '0);
      sb.delete();
      stalled_prev = 1'b0;
      step(1'b1, 16'd100, 16'd100, 1'b0, 4'd9, 1'b1, 32'd9216, acc);
      check("post_rst_accept", acc, 1'b1);
      check("lat_edge1", o_valid, 1'b0);
      step(1'b0, '0, '0, 1'b0, '0, 1'b1, '0, acc);
      check("lat_edge2", o_valid, 1'b0);
      step(1'b0, '0, '0, 1'b0, '0, 1'b1, '0, acc);
      check("lat_edge3", o_valid, 1'b1);
      drain();

      // Unsigned instance
      u_op("u_ffff_approx", 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0000);
      u_op("u_ffff_exact",  16'hFFFF, 16'hFFFF, 1'b1, 32'hFFFE_0001);
      u_op("u_c000_x1",     16'hC000, 16'd1,    1'b0, 32'h0000_C000);
      u_op("u_c000_sq",     16'hC000, 16'hC000, 1'b0, 32'h8000_0000);

      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
